pulse_sequencer: RTL and testbench

Autonomous note sequencer and register arbiter for the pulse channel in the chiptune design. It sits between the serial register decoder and the pulse channel. When playback is idle, host register writes pass through. When play is requested, a 16-step internal song ROM is stepped at the quarter-frame rate and drives the four channel registers and the change strobe.

---
 rtl/pulse_sequencer.sv | 173 +++++++++++++++++
 tb/tb_pulse_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sequencer.sv
// Pulse-channel note sequencer: steps a fixed 16-entry song ROM on quarter-frame
// rises and arbitrates the four channel registers against host register writes.
module pulse_sequencer #(
  parameter logic [3:0] VOLUME = 4'hF,
  parameter bit         LOOP   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       qtr_clk,
  input  logic       play,
  input  logic [7:0] host_reg_0,
  input  logic [7:0] host_reg_1,
  input  logic [7:0] host_reg_2,
  input  logic [7:0] host_reg_3,
  input  logic       host_change,
  output logic [7:0] reg_0,
  output logic [7:0] reg_1,
  output logic [7:0] reg_2,
  output logic [7:0] reg_3,
  output logic       change,
  output logic [3:0] step,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOAD, STROBE, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  step_reg, step_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [7:0]  regs_reg [4];
  logic [7:0]  regs_next [4];
  logic        change_reg, change_next;
  logic        play_q_reg, qtr_q_reg, host_q_reg;
  logic        host_load_reg, host_load_next;
  logic        host_strobe_reg, host_strobe_next;

  logic        play_rise, qtr_rise, host_rise;
  logic [16:0] entry;
  logic [10:0] period;
  logic [1:0]  duty;
  logic [3:0]  dur;

  // Entry layout: {period[10:0], duty[1:0], dur[3:0]}; dur == 0 marks the end of the song.
  function automatic logic [16:0] rom_entry(input logic [3:0] addr);
    case (addr)
      4'd0:    rom_entry = {11'h0FD, 2'd2, 4'd2};
      4'd1:    rom_entry = {11'h0E1, 2'd1, 4'd2};
      4'd2:    rom_entry = {11'h000, 2'd0, 4'd1};
      4'd3:    rom_entry = {11'h0BE, 2'd2, 4'd4};
      default: rom_entry = 17'd0;
    endcase
  endfunction

  assign entry  = rom_entry(step_reg);
  assign period = entry[16:6];
  assign duty   = entry[5:4];
  assign dur    = entry[3:0];

  assign play_rise = play & ~play_q_reg;
  assign qtr_rise  = qtr_clk & ~qtr_q_reg;
  assign host_rise = host_change & ~host_q_reg;

  always_comb begin
    state_next       = state_reg;
    step_next        = step_reg;
    cnt_next         = cnt_reg;
    regs_next        = regs_reg;
    change_next      = 1'b0;
    host_load_next   = host_rise;
    host_strobe_next = host_load_reg;

    if (host_rise) begin
      // Host write preempts playback; any pending ROM strobe is dropped.
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          // A play rise while a host update is still in flight is discarded.
          if (play_rise && !host_load_reg && !host_strobe_reg) begin
            step_next  = 4'd0;
            state_next = LOAD;
          end
        end
        LOAD: begin
          if (dur != 4'd0) begin
            if (period == 11'd0) begin
              regs_next[0] = 8'h30;
            end else begin
              regs_next[0] = {duty, 2'b11, VOLUME};
              regs_next[1] = 8'h00;
              regs_next[2] = period[7:0];
              regs_next[3] = {5'b00001, period[10:8]};
            end
            state_next = STROBE;
          end else if (LOOP) begin
            step_next = 4'd0;
          end else begin
            regs_next[0] = 8'h30;
            regs_next[1] = 8'h00;
            regs_next[2] = 8'h00;
            regs_next[3] = 8'h00;
            state_next   = STROBE;
          end
        end
        STROBE: begin
          change_next = 1'b1;
          cnt_next    = dur;
          // Only the stop-silence entry reaches STROBE with dur == 0.
          state_next  = (dur == 4'd0) ? IDLE : HOLD;
        end
        HOLD: begin
          if (qtr_rise) begin
            if (cnt_reg == 4'd1) begin
              step_next  = step_reg + 4'd1;
              state_next = LOAD;
            end else begin
              cnt_next = cnt_reg - 4'd1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (host_load_reg) begin
      regs_next[0] = host_reg_0;
      regs_next[1] = host_reg_1;
      regs_next[2] = host_reg_2;
      regs_next[3] = host_reg_3;
    end
    if (host_strobe_reg) begin
      change_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      step_reg        <= 4'd0;
      cnt_reg         <= 4'd0;
      regs_reg[0]     <= 8'h30;
      regs_reg[1]     <= 8'h00;
      regs_reg[2]     <= 8'h00;
      regs_reg[3]     <= 8'h00;
      change_reg      <= 1'b0;
      play_q_reg      <= 1'b0;
      qtr_q_reg       <= 1'b0;
      host_q_reg      <= 1'b0;
      host_load_reg   <= 1'b0;
      host_strobe_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      step_reg        <= step_next;
      cnt_reg         <= cnt_next;
      regs_reg        <= regs_next;
      change_reg      <= change_next;
      play_q_reg      <= play;
      qtr_q_reg       <= qtr_clk;
      host_q_reg      <= host_change;
      host_load_reg   <= host_load_next;
      host_strobe_reg <= host_strobe_next;
    end
  end

  assign reg_0  = regs_reg[0];
  assign reg_1  = regs_reg[1];
  assign reg_2  = regs_reg[2];
  assign reg_3  = regs_reg[3];
  assign change = change_reg;
  assign step   = step_reg;
  assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_pulse_sequencer.sv
// Randomized bench for pulse_sequencer: a looping and a one-shot instance share stimulus
// and are compared against a strobe-schedule model built from the song table.
module tb_pulse_sequencer;

  localparam int NCYC = 20000;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, qtr_clk, play, host_change;
  logic [7:0] host_reg_0, host_reg_1, host_reg_2, host_reg_3;
  logic [7:0] dut_regs [2][4];
  logic       dut_change [2];
  logic [3:0] dut_step [2];
  logic       dut_busy [2];

  pulse_sequencer #(.VOLUME(4'hF), .LOOP(1'b1)) u_loop (
    .clk(clk), .rst(rst), .qtr_clk(qtr_clk), .play(play),
    .host_reg_0(host_reg_0), .host_reg_1(host_reg_1),
    .host_reg_2(host_reg_2), .host_reg_3(host_reg_3),
    .host_change(host_change),
    .reg_0(dut_regs[0][0]), .reg_1(dut_regs[0][1]),
    .reg_2(dut_regs[0][2]), .reg_3(dut_regs[0][3]),
    .change(dut_change[0]), .step(dut_step[0]), .busy(dut_busy[0])
  );

  pulse_sequencer #(.VOLUME(4'hF), .LOOP(1'b0)) u_once (
    .clk(clk), .rst(rst), .qtr_clk(qtr_clk), .play(play),
    .host_reg_0(host_reg_0), .host_reg_1(host_reg_1),
    .host_reg_2(host_reg_2), .host_reg_3(host_reg_3),
    .host_change(host_change),
    .reg_0(dut_regs[1][0]), .reg_1(dut_regs[1][1]),
    .reg_2(dut_regs[1][2]), .reg_3(dut_regs[1][3]),
    .change(dut_change[1]), .step(dut_step[1]), .busy(dut_busy[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Song as heard on the channel, packed {reg_3, reg_2, reg_1, reg_0}; step 2 is a rest.
  logic [31:0] song_regs [4] = '{32'h08FD00BF, 32'h08E1007F, 32'h00000030, 32'h08BE00BF};
  int          song_dur  [4] = '{2, 2, 1, 4};
  string       nm        [2] = '{"loop", "once"};
  int          loop_mode [2] = '{1, 0};

  typedef struct {
    int          cyc;
    bit          rom;
    logic [31:0] regs;
    int          stp;
    int          dur;
  } exp_t;

  exp_t        pend [2][4];
  int          npend [2];
  int          playing [2], pos [2], counting [2], left [2], stop_cyc [2];
  logic [31:0] last_regs [2], prev_regs [2];
  logic        p_play, p_qtr, p_host;
  int          n_strobes;

  function automatic logic [31:0] pack_out(input int k);
    return {dut_regs[k][3], dut_regs[k][2], dut_regs[k][1], dut_regs[k][0]};
  endfunction

  task automatic push(input int k, input int c, input bit rom, input logic [31:0] regs,
                      input int stp, input int dur);
    if (npend[k] < 4) begin
      pend[k][npend[k]] = '{cyc: c, rom: rom, regs: regs, stp: stp, dur: dur};
      npend[k]++;
    end
  endtask

  task automatic schedule_note(input int k, input int idx, input int at);
    logic [31:0] r;
    r = (idx == 2) ? {last_regs[k][31:8], 8'h30} : song_regs[idx];
    last_regs[k] = r;
    push(k, at, 1'b1, r, idx, song_dur[idx]);
  endtask

  task automatic model_edge(input int n);
    bit host_r, play_r, qtr_r;
    host_r = host_change & ~p_host;
    play_r = play & ~p_play;
    qtr_r  = qtr_clk & ~p_qtr;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        npend[k] = 0; playing[k] = 0; counting[k] = 0; stop_cyc[k] = -1;
        last_regs[k] = 32'h00000030;
      end else if (host_r) begin
        int j = 0;
        for (int i = 0; i < npend[k]; i++)
          if (!pend[k][i].rom) begin pend[k][j] = pend[k][i]; j++; end
        npend[k] = j;
        last_regs[k] = {host_reg_3, host_reg_2, host_reg_1, host_reg_0};
        push(k, n + 2, 1'b0, last_regs[k], -1, 0);
        playing[k] = 0; counting[k] = 0; stop_cyc[k] = -1;
      end else begin
        if (play_r && playing[k] == 0) begin
          playing[k] = 1; pos[k] = 0;
          schedule_note(k, 0, n + 2);
        end
        if (qtr_r && counting[k] != 0) begin
          left[k]--;
          if (left[k] == 0) begin
            counting[k] = 0;
            pos[k]++;
            if (pos[k] < 4) begin
              schedule_note(k, pos[k], n + 2);
            end else if (loop_mode[k] != 0) begin
              pos[k] = 0;
              schedule_note(k, 0, n + 3);
            end else begin
              last_regs[k] = 32'h00000030;
              push(k, n + 2, 1'b1, 32'h00000030, 4, 0);
              stop_cyc[k] = n + 2;
            end
          end
        end
        if (stop_cyc[k] == n) begin
          playing[k] = 0; stop_cyc[k] = -1;
        end
      end
    end
    if (rst) begin p_play = 0; p_qtr = 0; p_host = 0; end
    else begin p_play = play; p_qtr = qtr_clk; p_host = host_change; end
  endtask

  task automatic check_outputs(input int n);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        check($sformatf("%s.rst_regs", nm[k]), pack_out(k), 32'h00000030);
        check($sformatf("%s.rst_change", nm[k]), {31'd0, dut_change[k]}, 32'd0);
        check($sformatf("%s.rst_busy", nm[k]), {31'd0, dut_busy[k]}, 32'd0);
        check($sformatf("%s.rst_step", nm[k]), {28'd0, dut_step[k]}, 32'd0);
      end else begin
        bit expc;
        expc = (npend[k] > 0) && (pend[k][0].cyc == n);
        check($sformatf("%s.change@%0d", nm[k], n), {31'd0, dut_change[k]}, {31'd0, expc});
        if (expc) begin
          exp_t e;
          e = pend[k][0];
          n_strobes++;
          $display("strobe %s cyc=%0d regs=%08h step=%0d busy=%0d", nm[k], n, pack_out(k),
                   dut_step[k], dut_busy[k]);
          check($sformatf("%s.regs@%0d", nm[k], n), pack_out(k), e.regs);
          check($sformatf("%s.stable@%0d", nm[k], n), prev_regs[k], e.regs);
          if (e.stp >= 0)
            check($sformatf("%s.step@%0d", nm[k], n), {28'd0, dut_step[k]}, e.stp);
          if (e.rom && e.dur > 0) begin counting[k] = 1; left[k] = e.dur; end
          for (int i = 1; i < npend[k]; i++) pend[k][i-1] = pend[k][i];
          npend[k]--;
        end
        check($sformatf("%s.busy@%0d", nm[k], n), {31'd0, dut_busy[k]}, playing[k]);
      end
      prev_regs[k] = pack_out(k);
    end
  endtask

  initial begin
    int rst_left, play_left, host_left, qtr_left, last_host, n_hosts;
    rst_left = 3; play_left = 0; host_left = 0; qtr_left = 5; last_host = -100; n_hosts = 0;
    n_strobes = 0;
    rst = 1'b1; qtr_clk = 1'b0; play = 1'b0; host_change = 1'b0;
    host_reg_0 = 8'h00; host_reg_1 = 8'h00; host_reg_2 = 8'h00; host_reg_3 = 8'h00;
    p_play = 0; p_qtr = 0; p_host = 0;
    for (int k = 0; k < 2; k++) begin
      npend[k] = 0; playing[k] = 0; pos[k] = 0; counting[k] = 0; left[k] = 0;
      stop_cyc[k] = -1; last_regs[k] = 32'h30; prev_regs[k] = 32'h30;
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // Quarter-frame pulse train with random spacing.
      if (qtr_left > 0) qtr_left--;
      else begin
        qtr_clk  = ~qtr_clk;
        qtr_left = qtr_clk ? $urandom_range(2, 0) : $urandom_range(20, 2);
      end

      if (rst_left == 0 && cyc > 50 && $urandom_range(1999, 0) == 0)
        rst_left = $urandom_range(3, 1);
      rst = (rst_left > 0);
      if (rst_left > 0) rst_left--;

      if (rst) begin
        play = 1'b0; play_left = 0; host_change = 1'b0; host_left = 0;
      end else begin
        if (host_left > 0) host_left--;
        else if (host_change) host_change = 1'b0;
        else if ((cyc + 1) - last_host >= 3 && $urandom_range(349, 0) == 0) begin
          if (n_hosts == 0) begin
            host_reg_0 = 8'h8F; host_reg_1 = 8'h00; host_reg_2 = 8'h40; host_reg_3 = 8'h09;
          end else begin
            host_reg_0 = 8'($urandom); host_reg_1 = 8'($urandom);
            host_reg_2 = 8'($urandom); host_reg_3 = 8'($urandom);
          end
          n_hosts++;
          host_change = 1'b1;
          host_left   = $urandom_range(3, 0);
          last_host   = cyc + 1;
          if (!play && $urandom_range(3, 0) == 0) begin
            play = 1'b1; play_left = $urandom_range(30, 0);
          end
        end

        if (play_left > 0) play_left--;
        else if (play && last_host != cyc + 1) play = 1'b0;
        else if (!play && (cyc + 1) - last_host >= 3 && $urandom_range(59, 0) == 0) begin
          play      = 1'b1;
          play_left = ($urandom_range(3, 0) == 0) ? $urandom_range(60, 20) : $urandom_range(3, 0);
        end
      end

      @(posedge clk);
      model_edge(cyc + 1);
      #1;
      check_outputs(cyc + 1);
    end

    check("strobes_seen", {31'd0, (n_strobes > 20)}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
